lfsr_param: RTL

Parametrised successor to the fixed 16-bit LFSR. Generates a pseudo-random sequence of configurable width and polynomial, in Fibonacci or Galois form. Adds seed load, all-zero lock-up recovery, saturating ones/zeros bit statistics and measured sequence period. Sits in the Part C test-pattern path as the stimulus source for the BIST and counter labs.

---
 rtl/lfsr_pkg.sv | 10 +
 rtl/lfsr_param_if.sv | 28 ++
 rtl/sat_counter.sv | 21 ++
 rtl/lfsr_param.sv | 103 ++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the parametrised LFSR: mode encodings and default tap masks.
// No logic; latency and backpressure are not applicable.
package lfsr_pkg;
    localparam bit MODE_FIB = 1'b0;
    localparam bit MODE_GAL = 1'b1;

    localparam logic [3:0]  TAPS_4  = 4'hC;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
endpackage

// File: rtl/lfsr_param_if.sv
// Control and status bundle of lfsr_param; master drives step/load, slave is the LFSR.
// Pure wiring, no latency; there is no backpressure, the LFSR accepts every cycle.
interface lfsr_param_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16,
    parameter int PER_W = WIDTH
);
    logic             sh_en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] Q_out;
    logic             out_bit;
    logic [CNT_W-1:0] ones;
    logic [CNT_W-1:0] zeros;
    logic [PER_W-1:0] period;
    logic             max_tick_reg;
    logic             lockup;

    modport master (
        output sh_en, load, load_val,
        input  Q_out, out_bit, ones, zeros, period, max_tick_reg, lockup
    );

    modport slave (
        input  sh_en, load, load_val,
        output Q_out, out_bit, ones, zeros, period, max_tick_reg, lockup
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones, never wraps.
// One-cycle update latency; clr has priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && !(&q)) begin
            q <= q + 1'b1;
        end
    end
endmodule

// File: rtl/lfsr_param.sv
// Parametrised Fibonacci/Galois LFSR with seed load, lock-up recovery, bit stats and period.
// All outputs registered, one cycle after sh_en/load; accepts a step every cycle.
module lfsr_param
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter bit               MODE  = MODE_GAL,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_16),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               CNT_W = 16,
    parameter int               PER_W = WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    lfsr_param_if.slave  bus
);
    logic [WIDTH-1:0] q;
    logic             out_bit_r;
    logic             tick_r;
    logic [PER_W-1:0] period_r;
    logic [PER_W-1:0] step_cnt;

    logic [WIDTH-1:0] shifted;
    logic             shift_out;
    logic             lock;
    logic             normal_step;
    logic             hits_seed;

    assign lock = (q == '0);

    always_comb begin
        shifted   = q;
        shift_out = 1'b0;
        if (MODE == MODE_FIB) begin
            shifted   = {q[WIDTH-2:0], ^(q & TAPS)};
            shift_out = q[WIDTH-1];
        end else begin
            shifted   = (q >> 1) ^ (q[0] ? TAPS : '0);
            shift_out = q[0];
        end
    end

    // A step from the all-zero state is recovery to SEED, not a counted step.
    assign normal_step = bus.sh_en && !bus.load && !lock;
    assign hits_seed   = (shifted == SEED);

    always_ff @(posedge clk) begin
        if (reset) begin
            q         <= SEED;
            out_bit_r <= 1'b0;
            tick_r    <= 1'b0;
            period_r  <= '0;
        end else begin
            tick_r <= 1'b0;
            if (bus.load) begin
                q         <= bus.load_val;
                out_bit_r <= 1'b0;
            end else if (bus.sh_en) begin
                if (lock) begin
                    q         <= SEED;
                    out_bit_r <= 1'b0;
                end else begin
                    q         <= shifted;
                    out_bit_r <= shift_out;
                    if (hits_seed) begin
                        tick_r   <= 1'b1;
                        period_r <= (&step_cnt) ? step_cnt : step_cnt + 1'b1;
                    end
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.load),
        .inc   (normal_step && shift_out),
        .q     (bus.ones)
    );

    sat_counter #(.W(CNT_W)) u_zeros (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.load),
        .inc   (normal_step && !shift_out),
        .q     (bus.zeros)
    );

    sat_counter #(.W(PER_W)) u_step_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.load || (normal_step && hits_seed)),
        .inc   (normal_step),
        .q     (step_cnt)
    );

    assign bus.Q_out        = q;
    assign bus.out_bit      = out_bit_r;
    assign bus.period       = period_r;
    assign bus.max_tick_reg = tick_r;
    assign bus.lockup       = lock;
endmodule
